// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM encodings, error data
// and the standard memory map (data RAM, instruction ROM, GPIO, UART).
package mmio_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
  localparam logic [31:0] DATA_MASK  = 32'h0000_FFFF;
  localparam logic [31:0] INSTR_BASE = 32'h0040_0000;
  localparam logic [31:0] INSTR_MASK = 32'h000F_FFFF;
  localparam logic [31:0] GPIO_BASE  = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_MASK  = 32'h0000_00FF;
  localparam logic [31:0] UART_BASE  = 32'hFFFF_0100;
  localparam logic [31:0] UART_MASK  = 32'h0000_00FF;

  localparam int STD_NUM_SLAVES = 4;
  localparam logic [127:0] STD_BASE_ADDRS = {UART_BASE, GPIO_BASE, INSTR_BASE, DATA_BASE};
  localparam logic [127:0] STD_ADDR_MASKS = {UART_MASK, GPIO_MASK, INSTR_MASK, DATA_MASK};

  // A single slave still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold TIMEOUT_CYCLES itself; one bit when timeout is disabled.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/mmio_addr_decoder.sv
// Combinational region decoder: per-slave hit vector, miss flag and the
// index of the lowest-numbered hit.
module mmio_addr_decoder
  import mmio_pkg::*;
#(
  parameter int                                ADDR_LENGTH = 32,
  parameter int                                NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] BASE_ADDRS  = STD_BASE_ADDRS,
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] ADDR_MASKS  = STD_ADDR_MASKS,
  parameter int                                IDX_W       = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_LENGTH-1:0] addr,
  output logic [NUM_SLAVES-1:0]  hit,
  output logic                   miss,
  output logic [IDX_W-1:0]       idx
);

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_region
    localparam logic [ADDR_LENGTH-1:0] BASE = BASE_ADDRS[i*ADDR_LENGTH +: ADDR_LENGTH];
    localparam logic [ADDR_LENGTH-1:0] MASK = ADDR_MASKS[i*ADDR_LENGTH +: ADDR_LENGTH];
    assign hit[i] = ((addr ^ BASE) & ~MASK) == '0;
  end

  assign miss = ~|hit;

  // Scanning downward lets the lowest-indexed hit overwrite the others.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mmio_bus_interconnect.sv
// Memory-mapped interconnect: one master port to NUM_SLAVES slave channels with
// registered IDLE/ACCESS/RESP handshake, bus timeout and unmapped-address errors.
module mmio_bus_interconnect
  import mmio_pkg::*;
#(
  parameter int                                DATA_LENGTH    = 32,
  parameter int                                ADDR_LENGTH    = 32,
  parameter int                                NUM_SLAVES     = STD_NUM_SLAVES,
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] BASE_ADDRS     = STD_BASE_ADDRS,
  parameter logic [NUM_SLAVES*ADDR_LENGTH-1:0] ADDR_MASKS     = STD_ADDR_MASKS,
  parameter int                                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_LENGTH-1:0]            ERR_RDATA      = DATA_LENGTH'(ERR_RDATA_DEFAULT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mst_req,
  input  logic                             mst_we,
  input  logic [ADDR_LENGTH-1:0]           mst_addr,
  input  logic [DATA_LENGTH-1:0]           mst_wdata,
  output logic                             mst_ready,
  output logic [DATA_LENGTH-1:0]           mst_rdata,
  output logic                             mst_err,
  output logic [NUM_SLAVES-1:0]            slv_sel,
  output logic                             slv_we,
  output logic [ADDR_LENGTH-1:0]           slv_addr,
  output logic [DATA_LENGTH-1:0]           slv_wdata,
  input  logic [NUM_SLAVES*DATA_LENGTH-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]            slv_ready
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       sel_idx;
  logic [NUM_SLAVES-1:0]  dec_hit;
  logic                   dec_miss;
  logic [IDX_W-1:0]       dec_idx;
  logic [ADDR_LENGTH-1:0] dec_mask;
  logic [DATA_LENGTH-1:0] sel_rdata;
  logic                   sel_ready;
  logic                   timeout_hit;

  mmio_addr_decoder #(
    .ADDR_LENGTH(ADDR_LENGTH),
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .addr(mst_addr),
    .hit (dec_hit),
    .miss(dec_miss),
    .idx (dec_idx)
  );

  always_comb begin
    dec_mask    = ADDR_MASKS[int'(dec_idx)*ADDR_LENGTH +: ADDR_LENGTH];
    sel_rdata   = slv_rdata[int'(sel_idx)*DATA_LENGTH +: DATA_LENGTH];
    // Masking with the registered select makes unselected slaves' ready irrelevant.
    sel_ready   = |(slv_ready & slv_sel);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sel_idx   <= '0;
      mst_ready <= 1'b0;
      mst_err   <= 1'b0;
      mst_rdata <= '0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      mst_ready <= 1'b0;
      mst_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mst_req) begin
            slv_wdata <= mst_wdata;
            if (dec_miss) begin
              state     <= ST_RESP;
              mst_ready <= 1'b1;
              mst_err   <= 1'b1;
              mst_rdata <= ERR_RDATA;
            end else begin
              state    <= ST_ACCESS;
              cnt      <= '0;
              sel_idx  <= dec_idx;
              slv_sel  <= NUM_SLAVES'(1) << dec_idx;
              slv_we   <= mst_we;
              slv_addr <= mst_addr & dec_mask;
            end
          end
        end
        ST_ACCESS: begin
          // A ready arriving on the timeout cycle still completes normally.
          if (sel_ready || timeout_hit) begin
            state     <= ST_RESP;
            mst_ready <= 1'b1;
            mst_err   <= ~sel_ready;
            mst_rdata <= !sel_ready ? ERR_RDATA : (slv_we ? '0 : sel_rdata);
            slv_sel   <= '0;
            slv_we    <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_interconnect.sv
// Scoreboard bench: stimulus pushes expected responses computed from the address
// map rules; a monitor pops and compares on each mst_ready strobe.
module tb_mmio_bus_interconnect;

  localparam int N  = 4;
  localparam int TO = 4;
  // Slave 3 is a wide region that fully contains slave 0's region.
  localparam logic [127:0] BASES = {32'h1000_0000, 32'hFFFF_0000, 32'h0040_0000, 32'h1001_0000};
  localparam logic [127:0] MASKS = {32'h000F_FFFF, 32'h0000_00FF, 32'h000F_FFFF, 32'h0000_FFFF};

  logic         clk = 1'b0;
  logic         rst;
  logic         mst_req, mst_we;
  logic [31:0]  mst_addr, mst_wdata;
  logic         mst_ready, mst_err;
  logic [31:0]  mst_rdata;
  logic [N-1:0] slv_sel;
  logic         slv_we;
  logic [31:0]  slv_addr, slv_wdata;
  logic [127:0] slv_rdata;
  logic [N-1:0] slv_ready;

  mmio_bus_interconnect #(
    .DATA_LENGTH   (32),
    .ADDR_LENGTH   (32),
    .NUM_SLAVES    (N),
    .BASE_ADDRS    (BASES),
    .ADDR_MASKS    (MASKS),
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mst_req  (mst_req),
    .mst_we   (mst_we),
    .mst_addr (mst_addr),
    .mst_wdata(mst_wdata),
    .mst_ready(mst_ready),
    .mst_rdata(mst_rdata),
    .mst_err  (mst_err),
    .slv_sel  (slv_sel),
    .slv_we   (slv_we),
    .slv_addr (slv_addr),
    .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata),
    .slv_ready(slv_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory map, slave index order.
  logic [31:0] m_base [N] = '{32'h1001_0000, 32'h0040_0000, 32'hFFFF_0000, 32'h1000_0000};
  logic [31:0] m_mask [N] = '{32'h0000_FFFF, 32'h000F_FFFF, 32'h0000_00FF, 32'h000F_FFFF};

  typedef struct {
    string       name;
    int          ready_cyc;
    logic        err;
    logic [31:0] rdata;
    int          acc_cycles;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int passed = 0;

  // Current transaction as seen by the slave responder.
  int          cur_tgt = -1;
  int          cur_delay = 0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_sdata = '0;
  int          sel_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int model_target(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (((a ^ m_base[i]) & ~m_mask[i]) == 32'h0) return i;
    return -1;
  endfunction

  // lead: posedges until the DUT samples this request.
  task automatic start(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay, input logic [31:0] sdata,
                       input int lead);
    exp_t e;
    int a;
    cur_tgt   = model_target(addr);
    cur_delay = delay;
    cur_we    = we;
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_sdata = sdata;
    mst_req   = 1'b1;
    mst_we    = we;
    mst_addr  = addr;
    mst_wdata = wdata;
    a = cyc + lead;
    e.name = name;
    if (cur_tgt < 0) begin
      e.ready_cyc = a;  e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.acc_cycles = 0;
    end else if (delay < TO) begin
      e.ready_cyc = a + delay + 1; e.err = 1'b0;
      e.rdata = we ? 32'h0 : sdata; e.acc_cycles = delay + 1;
    end else begin
      e.ready_cyc = a + TO; e.err = 1'b1; e.rdata = 32'hDEAD_BEEF; e.acc_cycles = TO;
    end
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input bit scramble);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (scramble && !mst_req) begin
        mst_we    = 1'($urandom);
        mst_addr  = $urandom;
        mst_wdata = $urandom;
      end
      if (sb.size() == 0) break;
    end
    check({name, " completed"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input logic [31:0] sdata);
    @(negedge clk);
    start(name, we, addr, wdata, delay, sdata, 1);
    @(negedge clk);
    mst_req = 1'b0;
    wait_done(name, 1'b1);
  endtask

  // Slave responder: random data and ready on every channel, target follows the model.
  always @(negedge clk) begin
    slv_ready = 4'($urandom);
    slv_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (slv_sel != '0) begin
      check("slv_sel", 32'(slv_sel), (cur_tgt < 0) ? 32'h0 : (32'h1 << cur_tgt));
      check("slv_we", 32'(slv_we), 32'(cur_we));
      if (cur_tgt >= 0) check("slv_addr", slv_addr, cur_addr & m_mask[cur_tgt]);
      if (cur_we) check("slv_wdata", slv_wdata, cur_wdata);
      if (cur_tgt >= 0) begin
        slv_ready[cur_tgt] = (sel_cnt == cur_delay);
        slv_rdata[cur_tgt*32 +: 32] = cur_sdata;
      end
      sel_cnt++;
    end
  end

  // Monitor: compare every completion strobe against the scoreboard head.
  always @(negedge clk) begin
    if (mst_ready) begin
      if (sb.size() == 0) begin
        check("spurious mst_ready", 32'(mst_ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " latency"}, 32'(cyc), 32'(e.ready_cyc));
        check({e.name, " err"}, 32'(mst_err), 32'(e.err));
        check({e.name, " rdata"}, mst_rdata, e.rdata);
        check({e.name, " access cycles"}, 32'(sel_cnt), 32'(e.acc_cycles));
      end
      sel_cnt = 0;
    end
  end

  initial begin
    rst = 1'b0;
    mst_req = 1'b0; mst_we = 1'b0; mst_addr = '0; mst_wdata = '0;
    slv_ready = '0; slv_rdata = '0;
    #12;
    check("reset mst_ready", 32'(mst_ready), 32'd0);
    check("reset mst_err", 32'(mst_err), 32'd0);
    check("reset mst_rdata", mst_rdata, 32'd0);
    check("reset slv_sel", 32'(slv_sel), 32'd0);
    check("reset slv_we", 32'(slv_we), 32'd0);
    check("reset slv_addr", slv_addr, 32'd0);
    check("reset slv_wdata", slv_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_txn("rd_instr", 1'b0, 32'h0040_0004, 32'h0, 0, 32'h0000_0013);
    run_txn("wr_gpio", 1'b1, 32'hFFFF_0000, 32'h0000_00A5, 3, 32'h1234_5678);
    run_txn("unmapped", 1'b0, 32'h8000_0000, 32'h0, 0, 32'h0);
    run_txn("timeout", 1'b0, 32'h0040_0010, 32'h0, 99, 32'h0);
    run_txn("ready_on_last", 1'b0, 32'h1000_0040, 32'h0, TO - 1, 32'hCAFE_F00D);

    // Overlapping hit with mst_req held through RESP: second access follows RESP+IDLE.
    @(negedge clk);
    start("overlap", 1'b0, 32'h1001_0010, 32'h0, 1, 32'h0BAD_F00D, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    check("overlap completed", 32'(sb.size()), 32'd0);
    start("back_to_back", 1'b0, 32'h1000_0020, 32'h0, 0, 32'h3333_4444, 2);
    @(negedge clk);
    @(negedge clk);
    mst_req = 1'b0;
    wait_done("back_to_back", 1'b1);

    // Reset during ACCESS abandons the transaction with no strobe.
    @(negedge clk);
    start("abandoned", 1'b1, 32'h0040_0100, 32'h5555_AAAA, 99, 32'h0, 1);
    @(negedge clk);
    mst_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid reset slv_sel", 32'(slv_sel), 32'd0);
    check("mid reset slv_we", 32'(slv_we), 32'd0);
    check("mid reset mst_ready", 32'(mst_ready), 32'd0);
    check("mid reset slv_addr", slv_addr, 32'd0);
    sb.delete();
    sel_cnt = 0;
    cur_tgt = -1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("post reset idle sel", 32'(slv_sel), 32'd0);
      check("post reset idle ready", 32'(mst_ready), 32'd0);
    end
    run_txn("recover", 1'b0, 32'h1001_0008, 32'h0, 2, 32'h7777_8888);

    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic [31:0] addr;
      kind = $urandom_range(0, 5);
      if (kind < 4)       addr = m_base[kind] | ($urandom & m_mask[kind]);
      else if (kind == 4) addr = 32'h1001_0000 | ($urandom & 32'h0000_FFFF);
      else                addr = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFF);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn("rand", 1'($urandom), addr, $urandom, $urandom_range(0, 5), $urandom);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
